// File: rtl/dmem_arbiter.sv
// Purpose : arbitrates one data-memory port between the pipeline MEM stage and a DMA/loader burst engine.
// Latency : pipeline path is combinational (zero cycles); a granted burst starts one cycle after the request is seen.
// Backpressure: pipeline is held via P_Stall during bursts; DMA waits until the pipeline is idle or has won STARVE_MAX+1 cycles.
//
// Ports:
//   CLK, Reset            clock (state on falling edge), synchronous active-high reset
//   P_Req/P_Wr/P_Addr/P_WData -> P_Stall          pipeline access and its hold signal
//   D_Req/D_Wr/D_Addr/D_Len/D_WData -> D_Idx/D_Ack/D_Done   burst request and per-word handshake
//   M_Read/M_Write/M_Addr/M_WData/M_Sel           memory port; M_Sel steers read data (0 pipe, 1 DMA)
module dmem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              P_Req,
  input  logic              P_Wr,
  input  logic [ADDR_W-1:0] P_Addr,
  input  logic [DATA_W-1:0] P_WData,
  output logic              P_Stall,
  input  logic              D_Req,
  input  logic              D_Wr,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [2:0]        D_Len,
  input  logic [DATA_W-1:0] D_WData,
  output logic [2:0]        D_Idx,
  output logic              D_Ack,
  output logic              D_Done,
  output logic              M_Read,
  output logic              M_Write,
  output logic [ADDR_W-1:0] M_Addr,
  output logic [DATA_W-1:0] M_WData,
  output logic              M_Sel
);

  localparam logic [0:0] PIPE = 1'b0;
  localparam logic [0:0] DMA  = 1'b1;
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [2:0]        lastIdx;
  logic [ADDR_W-1:0] baseAddr;
  logic              burstWr;

  logic [3:0]        lenEff;
  logic [2:0]        lenLastIdx;
  logic              starveHit;
  logic              grant;
  logic              lastWord;
  logic [ADDR_W-1:0] dmaAddr;

  // Effective burst length: 0 encodes a single word, anything past BURST_MAX is clamped.
  always_comb begin
    lenEff = (D_Len == 3'd0) ? 4'd1 : {1'b0, D_Len};
    if (lenEff > 4'(BURST_MAX)) begin
      lenEff = 4'(BURST_MAX);
    end
    lenLastIdx = 3'(lenEff - 4'd1);
  end

  // An idle pipeline yields at once; a busy one yields after winning STARVE_MAX+1 cycles.
  assign starveHit = (cnt == CNT_W'(STARVE_MAX));
  assign grant     = (state == PIPE) && D_Req && (!P_Req || starveHit);
  assign lastWord  = (state == DMA) && (idx == lastIdx);
  // Natural ADDR_W-bit overflow gives the wrap past the top address.
  assign dmaAddr   = baseAddr + ADDR_W'(idx);

  always_ff @(negedge CLK) begin
    if (Reset) begin
      state    <= PIPE;
      cnt      <= '0;
      idx      <= '0;
      lastIdx  <= '0;
      baseAddr <= '0;
      burstWr  <= 1'b0;
    end else begin
      case (state)
        PIPE: begin
          if (grant) begin
            state    <= DMA;
            cnt      <= '0;
            idx      <= '0;
            lastIdx  <= lenLastIdx;
            baseAddr <= D_Addr;
            burstWr  <= D_Wr;
          end else if (D_Req && P_Req) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        DMA: begin
          // D_Req is deliberately not looked at: a started burst always completes.
          if (lastWord) begin
            state <= PIPE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: begin
          state <= PIPE;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    M_Read  = P_Req & ~P_Wr;
    M_Write = P_Req & P_Wr;
    M_Addr  = P_Addr;
    M_WData = P_WData;
    M_Sel   = 1'b0;
    P_Stall = 1'b0;
    D_Ack   = 1'b0;
    D_Done  = 1'b0;
    D_Idx   = idx;
    if (state == DMA) begin
      M_Read  = ~burstWr;
      M_Write = burstWr;
      M_Addr  = dmaAddr;
      M_WData = D_WData;
      M_Sel   = 1'b1;
      P_Stall = P_Req;
      D_Ack   = 1'b1;
      D_Done  = lastWord;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed scoreboard bench for dmem_arbiter.
// Latency : expectations are queued when a cycle's inputs are driven and checked on the following rising edge.
// Backpressure: none; the bench drives one stimulus per cycle and never waits on the DUT.
module tb_dmem_arbiter;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              rst;
    logic              pReq;
    logic              pWr;
    logic [ADDR_W-1:0] pAddr;
    logic [DATA_W-1:0] pWData;
    logic              dReq;
    logic              dWr;
    logic [ADDR_W-1:0] dAddr;
    logic [2:0]        dLen;
    logic [DATA_W-1:0] dWData;
  } stim_t;

  typedef struct packed {
    logic [15:0]       cid;
    logic              mRead;
    logic              mWrite;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mWData;
    logic              mSel;
    logic              pStall;
    logic              dAck;
    logic              dDone;
    logic [2:0]        dIdx;
  } exp_t;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              P_Req, P_Wr;
  logic [ADDR_W-1:0] P_Addr;
  logic [DATA_W-1:0] P_WData;
  logic              P_Stall;
  logic              D_Req, D_Wr;
  logic [ADDR_W-1:0] D_Addr;
  logic [2:0]        D_Len;
  logic [DATA_W-1:0] D_WData;
  logic [2:0]        D_Idx;
  logic              D_Ack, D_Done;
  logic              M_Read, M_Write;
  logic [ADDR_W-1:0] M_Addr;
  logic [DATA_W-1:0] M_WData;
  logic              M_Sel;

  int   nRun  = 0;
  int   nFail = 0;
  int   cycNo = 0;
  exp_t expQ[$];

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4), .BURST_MAX(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .P_Req(P_Req), .P_Wr(P_Wr), .P_Addr(P_Addr), .P_WData(P_WData), .P_Stall(P_Stall),
    .D_Req(D_Req), .D_Wr(D_Wr), .D_Addr(D_Addr), .D_Len(D_Len), .D_WData(D_WData),
    .D_Idx(D_Idx), .D_Ack(D_Ack), .D_Done(D_Done),
    .M_Read(M_Read), .M_Write(M_Write), .M_Addr(M_Addr), .M_WData(M_WData), .M_Sel(M_Sel)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nRun++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t ePipe(input stim_t s);
    exp_t e;
    e        = '0;
    e.mRead  = s.pReq & ~s.pWr;
    e.mWrite = s.pReq & s.pWr;
    e.mAddr  = s.pAddr;
    e.mWData = s.pWData;
    return e;
  endfunction

  function automatic exp_t eDma(input stim_t s, input logic wr, input logic [ADDR_W-1:0] addr,
                                input int i, input logic done);
    exp_t e;
    e        = '0;
    e.mRead  = ~wr;
    e.mWrite = wr;
    e.mAddr  = addr;
    e.mWData = s.dWData;
    e.mSel   = 1'b1;
    e.pStall = s.pReq;
    e.dAck   = 1'b1;
    e.dDone  = done;
    e.dIdx   = 3'(i);
    return e;
  endfunction

  // Drive one cycle's inputs just after the state-updating falling edge and queue what the DUT must show.
  task automatic cyc(input stim_t s, input exp_t e);
    @(negedge CLK);
    #1;
    Reset   = s.rst;
    P_Req   = s.pReq;
    P_Wr    = s.pWr;
    P_Addr  = s.pAddr;
    P_WData = s.pWData;
    D_Req   = s.dReq;
    D_Wr    = s.dWr;
    D_Addr  = s.dAddr;
    D_Len   = s.dLen;
    D_WData = s.dWData;
    e.cid   = 16'(cycNo);
    cycNo++;
    expQ.push_back(e);
  endtask

  // Sample on the rising edge, half a period away from the falling state edge.
  always @(posedge CLK) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkVal($sformatf("c%0d.M_Read", e.cid),  32'(M_Read),  32'(e.mRead));
      checkVal($sformatf("c%0d.M_Write", e.cid), 32'(M_Write), 32'(e.mWrite));
      checkVal($sformatf("c%0d.M_Addr", e.cid),  32'(M_Addr),  32'(e.mAddr));
      checkVal($sformatf("c%0d.M_WData", e.cid), M_WData,      e.mWData);
      checkVal($sformatf("c%0d.M_Sel", e.cid),   32'(M_Sel),   32'(e.mSel));
      checkVal($sformatf("c%0d.P_Stall", e.cid), 32'(P_Stall), 32'(e.pStall));
      checkVal($sformatf("c%0d.D_Ack", e.cid),   32'(D_Ack),   32'(e.dAck));
      checkVal($sformatf("c%0d.D_Done", e.cid),  32'(D_Done),  32'(e.dDone));
      checkVal($sformatf("c%0d.D_Idx", e.cid),   32'(D_Idx),   32'(e.dIdx));
      checkVal($sformatf("c%0d.rw_excl", e.cid), 32'(M_Read & M_Write), 32'd0);
    end
  end

  initial begin
    #200000;
    nFail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    Reset = 1'b1; P_Req = 1'b0; P_Wr = 1'b0; P_Addr = '0; P_WData = '0;
    D_Req = 1'b0; D_Wr = 1'b0; D_Addr = '0; D_Len = '0; D_WData = '0;
    repeat (2) @(negedge CLK);

    // Reset state: pipeline owns memory, a load passes straight through.
    s = '0; s.pReq = 1'b1; s.pAddr = 6'd3; s.pWData = $urandom;
    cyc(s, ePipe(s));
    s = '0; s.pReq = 1'b1; s.pWr = 1'b1; s.pAddr = 6'd7; s.pWData = $urandom;
    cyc(s, ePipe(s));

    // Idle pipeline: 3-word write burst at 10; D_Req dropped mid-burst is ignored.
    s = '0; s.dReq = 1'b1; s.dWr = 1'b1; s.dAddr = 6'd10; s.dLen = 3'd3; s.dWData = $urandom;
    cyc(s, ePipe(s));
    for (int i = 0; i < 3; i++) begin
      s.dReq = 1'b0; s.dWData = $urandom;
      cyc(s, eDma(s, 1'b1, 6'(10 + i), i, i == 2));
    end
    s = '0;
    cyc(s, ePipe(s));

    // Starvation: busy pipeline gets 5 accesses before a 2-word read burst.
    for (int k = 0; k < 5; k++) begin
      s = '0; s.pReq = 1'b1; s.pAddr = 6'(k + 1); s.pWData = $urandom;
      s.dReq = 1'b1; s.dAddr = 6'd20; s.dLen = 3'd2;
      cyc(s, ePipe(s));
    end
    for (int i = 0; i < 2; i++) begin
      s.dWData = $urandom;
      cyc(s, eDma(s, 1'b0, 6'(20 + i), i, i == 1));
    end
    s = '0; s.pReq = 1'b1; s.pAddr = 6'd9;
    cyc(s, ePipe(s));

    // Address wrap: 62, 63, 0, 1.
    s = '0; s.dReq = 1'b1; s.dAddr = 6'd62; s.dLen = 3'd4;
    cyc(s, ePipe(s));
    for (int i = 0; i < 4; i++) begin
      s.dWData = $urandom;
      cyc(s, eDma(s, 1'b0, 6'(62 + i), i, i == 3));
    end
    s = '0;
    cyc(s, ePipe(s));

    // D_Len = 0 is a single word.
    s = '0; s.dReq = 1'b1; s.dAddr = 6'd33; s.dLen = 3'd0;
    cyc(s, ePipe(s));
    s.dReq = 1'b0; s.dWData = $urandom;
    cyc(s, eDma(s, 1'b0, 6'd33, 0, 1'b1));
    s = '0;
    cyc(s, ePipe(s));

    // D_Len = 7 is clamped to 4 words.
    s = '0; s.dReq = 1'b1; s.dWr = 1'b1; s.dAddr = 6'd30; s.dLen = 3'd7;
    cyc(s, ePipe(s));
    for (int i = 0; i < 4; i++) begin
      s.dReq = 1'b0; s.dWData = $urandom;
      cyc(s, eDma(s, 1'b1, 6'(30 + i), i, i == 3));
    end
    s = '0;
    cyc(s, ePipe(s));

    // Reset on the second word of a 4-word read burst aborts it.
    s = '0; s.dReq = 1'b1; s.dAddr = 6'd40; s.dLen = 3'd4;
    cyc(s, ePipe(s));
    s.dReq = 1'b0; s.dWData = $urandom;
    cyc(s, eDma(s, 1'b0, 6'd40, 0, 1'b0));
    s.rst = 1'b1; s.dWData = $urandom;
    cyc(s, eDma(s, 1'b0, 6'd41, 1, 1'b0));
    s = '0; s.pReq = 1'b1; s.pAddr = 6'd5; s.pWData = $urandom;
    cyc(s, ePipe(s));
    s = '0;
    cyc(s, ePipe(s));

    // Fairness: both sides always requesting -> 5 pipeline cycles then 3 DMA cycles, repeating.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        s = '0; s.pReq = 1'b1; s.pWr = k[0]; s.pAddr = 6'(k + 8 * r); s.pWData = $urandom;
        s.dReq = 1'b1; s.dWr = 1'b1; s.dAddr = 6'd50; s.dLen = 3'd3;
        cyc(s, ePipe(s));
      end
      for (int i = 0; i < 3; i++) begin
        s.dWData = $urandom;
        cyc(s, eDma(s, 1'b1, 6'(50 + i), i, i == 2));
      end
    end
    s = '0; s.pReq = 1'b1; s.pAddr = 6'd60; s.pWData = $urandom;
    cyc(s, ePipe(s));

    @(posedge CLK);
    #1;
    checkVal("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
